fir_sequencer: RTL

Host-side controller that drives the 16-tap FIR filter's shift-and-fire interface. It accepts coefficients and samples over valid/ready streams and generates the FIR's `wind`/`load`/`data`/`in_valid` strobes. It captures the FIR result on `out_valid` and returns it on a result stream. It sits between the system bus adapter and the FIR instance in the parent module.

---
 rtl/fir_seq_pkg.sv | 18 +
 rtl/fir_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fir_seq_pkg.sv
// Shared types and constants for the FIR host sequencer.
// The FIR instance reuses the tap and fire-length constants.
package fir_seq_pkg;

  localparam int FIR_TAPS        = 16;
  localparam int FIR_FIRE_CYCLES = 4;

  typedef enum logic [2:0] {
    IDLE,
    WIND,
    READY,
    LOAD,
    FIRE,
    WAIT,
    HOLD
  } fir_seq_state_t;

endpackage

// File: rtl/fir_sequencer.sv
// Drives the FIR shift/fire strobes from coefficient and sample
// streams and returns the captured FIR result on a result stream.
module fir_sequencer
  import fir_seq_pkg::*;
#(
  parameter int TAPS        = FIR_TAPS,
  parameter int FIRE_CYCLES = FIR_FIRE_CYCLES,
  parameter int TIMEOUT     = 15,
  parameter int DW          = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          coef_start,
  input  logic          coef_valid,
  input  logic [DW-1:0] coef_data,
  output logic          coef_ready,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic          r_valid,
  output logic [DW-1:0] r_data,
  input  logic          r_ready,
  output logic          err,
  output logic          cfg_done,
  output logic          fir_wind,
  output logic          fir_load,
  output logic          fir_in_valid,
  output logic [DW-1:0] fir_data,
  input  logic          fir_out_valid,
  input  logic [DW-1:0] fir_out
);

  localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int FW = $clog2(FIRE_CYCLES + 1);
  localparam int MW = $clog2(TIMEOUT + 1);

  fir_seq_state_t state_q, state_d;

  logic [TW-1:0] tap_q, tap_d;
  logic [FW-1:0] fire_q, fire_d;
  logic [MW-1:0] tmo_q, tmo_d;

  logic          wind_q, wind_d;
  logic          load_q, load_d;
  logic          inv_q, inv_d;
  logic [DW-1:0] data_q, data_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          cfg_q, cfg_d;

  // coef_start wins over a same-cycle sample
  logic s_rdy;
  assign s_rdy = (state_q == READY) && !coef_start;

  always_comb begin
    state_d  = state_q;
    tap_d    = tap_q;
    fire_d   = fire_q;
    tmo_d    = tmo_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cfg_d    = cfg_q;
    wind_d   = 1'b0;
    data_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (coef_start) begin
          state_d = WIND;
          tap_d   = '0;
        end
      end
      WIND: begin
        if (coef_valid) begin
          wind_d = 1'b1;
          data_d = coef_data;
          if (tap_q == TW'(TAPS - 1)) begin
            tap_d   = '0;
            cfg_d   = 1'b1;
            state_d = READY;
          end else begin
            tap_d = tap_q + TW'(1);
          end
        end
      end
      READY: begin
        if (coef_start) begin
          state_d = WIND;
          tap_d   = '0;
          cfg_d   = 1'b0;
        end else if (s_valid) begin
          data_d  = s_data;
          state_d = LOAD;
        end
      end
      LOAD: begin
        fire_d  = '0;
        state_d = FIRE;
      end
      FIRE: begin
        if (fir_out_valid) begin
          rdata_d  = fir_out;
          rvalid_d = 1'b1;
          state_d  = HOLD;
        end else if (fire_q == FW'(FIRE_CYCLES - 1)) begin
          tmo_d   = '0;
          state_d = WAIT;
        end else begin
          fire_d = fire_q + FW'(1);
        end
      end
      WAIT: begin
        if (fir_out_valid) begin
          rdata_d  = fir_out;
          rvalid_d = 1'b1;
          state_d  = HOLD;
        end else if (tmo_q == MW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = READY;
        end else begin
          tmo_d = tmo_q + MW'(1);
        end
      end
      HOLD: begin
        if (r_ready) begin
          rvalid_d = 1'b0;
          state_d  = READY;
        end
      end
      default: state_d = IDLE;
    endcase
    load_d = (state_d == LOAD);
    inv_d  = (state_d == FIRE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tap_q    <= '0;
      fire_q   <= '0;
      tmo_q    <= '0;
      wind_q   <= 1'b0;
      load_q   <= 1'b0;
      inv_q    <= 1'b0;
      data_q   <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cfg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tap_q    <= tap_d;
      fire_q   <= fire_d;
      tmo_q    <= tmo_d;
      wind_q   <= wind_d;
      load_q   <= load_d;
      inv_q    <= inv_d;
      data_q   <= data_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cfg_q    <= cfg_d;
    end
  end

  assign coef_ready   = (state_q == WIND);
  assign s_ready      = s_rdy;
  assign r_valid      = rvalid_q;
  assign r_data       = rdata_q;
  assign err          = err_q;
  assign cfg_done     = cfg_q;
  assign fir_wind     = wind_q;
  assign fir_load     = load_q;
  assign fir_in_valid = inv_q;
  assign fir_data     = data_q;

endmodule
